fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Shares the single write port of the 8-entry FIFO (control_module + storage) between two producers. Runs a round-robin burst arbiter and drives the FIFO's write_signal and write data one cycle after a grant. Tracks occupancy from its own writes and the consumer's read_signal, so it never grants into a full FIFO. Sits directly upstream of control_module in the FIFO subsystem.

Parameters:
DW, 8, data width of each producer and of write_data
DEPTH, 8, FIFO entries; must match control_module addressing (3-bit addresses)
AW, 3, log2(DEPTH)
MAX_BURST, 4, maximum consecutive grants to one requester while the other is requesting; range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req0  in  1  producer 0 has a datum on din0; held until gnt0 is seen
din0  in  DW  producer 0 data
req1  in  1  producer 1 request
din1  in  DW  producer 1 data
read_signal  in  1  consumer pop strobe, same signal that drives control_module
gnt0  out  1  combinational; din0 is consumed at this clock edge
gnt1  out  1  combinational; din1 is consumed at this clock edge
write_signal  out  1  registered write strobe to control_module
write_data  out  DW  registered datum accompanying write_signal
count  out  AW+1  registered occupancy, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset (rst=0, async): state=IDLE, last=1 (producer 0 wins first), burst_cnt=0, write_signal=0, write_data=0, count=0, full=0, empty=1. gnt0/gnt1=0 while rst=0. Reset mid-burst drops any in-flight write; no partial write is issued.
- Space: space = !full || (read_signal && !empty). A read in the same cycle frees a slot.
- At most one grant per cycle. gnt0 and gnt1 are never high together.
- FSM states: IDLE, BURST0, BURST1.
  - IDLE: if space, grant by round-robin. If both requesters are active, grant the one that is not "last". Otherwise grant the single requester. Enter BURSTx with burst_cnt=1 and set last=x.
  - BURSTx with reqx && space:
    - if burst_cnt<MAX_BURST or the other requester is idle: grant x and increment burst_cnt (saturating).
    - otherwise: switch and grant the other requester, enter BURSTother, burst_cnt=1.
  - BURSTx with !reqx: switch to the other requester if it is requesting and there is space, else go to IDLE.
  - BURSTx with !space: no grant; state and burst_cnt hold.
- Write path latency is 1: a grant at edge N gives write_signal=1 and write_data=din_x during cycle N+1. With no grant at edge N, write_signal=0 and write_data holds its value.
- Count is updated at the grant edge, reserving the slot:
  - +1 on grant only
  - −1 on read_signal && !empty only
  - unchanged on both or neither
  - read_signal while empty is ignored
- Count never exceeds DEPTH. Wrap-around of FIFO addresses is handled by control_module, not this block.

Optional Feature:
FIFO_ARB_STATS_EN
- When defined: adds outputs wr_cnt0 and wr_cnt1 (16 bits, accepted writes per producer) and stall_cnt (16 bits, cycles with any req high but no grant). All saturate at 16'hFFFF and reset to 0.
- When undefined: these ports and registers do not exist. Core behaviour is identical either way.

Decomposition:
- Package fifo_arb_pkg holds:
  - DEPTH and AW defaults
  - the state encoding typedef (IDLE=2'd0, BURST0=2'd1, BURST1=2'd2)
  - the burst-counter width constant
- One sub-module, fifo_occ_counter: the count register and the full/empty flags. Inputs are inc and dec; it is reusable on the read side.
- The FSM and the write register stay in the top module.

Test Plan:
- Reset then single producer: req0=1 for 3 cycles, din0=8'h11,8'h22,8'h33 → gnt0 high 3 cycles; write_signal high cycles 2–4 carrying 11,22,33; count=3.
- Both requesting continuously, MAX_BURST=4, FIFO drained every cycle → grant pattern 0,0,0,0,1,1,1,1,0,…; gnt0&gnt1 never 1.
- Fill with no reads: req0 held high → exactly 8 grants, then full=1, count=8, gnt0=0; assert read_signal for one cycle → exactly one further grant on that cycle, count stays 8.
- Simultaneous read and grant at count=5 → count stays 5; read_signal with count=0 → count stays 0, empty=1.
- Assert rst=0 asynchronously mid-burst (between clock edges) → all outputs reach reset values immediately; after release, producer 0 wins when both request.
- With FIFO_ARB_STATS_EN defined, 8 writes from producer 1 plus 3 stalled cycles → wr_cnt1=8, wr_cnt0=0, stall_cnt=3.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_arb_pkg                                                         |
// | Shared constants and state encoding for the FIFO write arbiter.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package fifo_arb_pkg;

    localparam int c_DEPTH   = 8;
    localparam int c_AW      = 3;
    // Wide enough for MAX_BURST values up to 15
    localparam int c_BURST_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST0 = 2'd1,
        BURST1 = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_occ_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_occ_counter                                                     |
// | Occupancy register with registered full/empty flags.                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fifo_occ_counter
    import fifo_arb_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int AW    = c_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] c_FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ONE      = (AW+1)'(1);

    logic [AW:0] w_count_next;

    always_comb begin
        w_count_next = count;
        if (inc && !dec)
            w_count_next = count + c_ONE;
        else if (dec && !inc)
            w_count_next = count - c_ONE;
    end

    // Flags track the next value so they line up with the count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            count <= w_count_next;
            full  <= (w_count_next == c_FULL_LVL);
            empty <= (w_count_next == '0);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_wr_arbiter                                                      |
// | Round-robin burst arbiter sharing the FIFO write port between two    |
// | producers. Optional statistics counters: define FIFO_ARB_STATS_EN.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int DEPTH     = c_DEPTH,
    parameter int AW        = c_AW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] din0,
    input  logic          req1,
    input  logic [DW-1:0] din1,
    input  logic          read_signal,
    output logic          gnt0,
    output logic          gnt1,
    output logic          write_signal,
    output logic [DW-1:0] write_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]   wr_cnt0,
    output logic [15:0]   wr_cnt1,
    output logic [15:0]   stall_cnt
`endif
);

    localparam logic [c_BURST_W-1:0] c_MAX_BURST = c_BURST_W'(MAX_BURST);
    localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);
    localparam logic [c_BURST_W-1:0] c_BURST_SAT = '1;

    arb_state_t           r_state;
    logic                 r_last;
    logic [c_BURST_W-1:0] r_burst_cnt;

    arb_state_t           w_state_next;
    logic                 w_last_next;
    logic [c_BURST_W-1:0] w_burst_next;
    logic                 w_gnt0;
    logic                 w_gnt1;
    logic                 w_space;
    logic                 w_dec;

    assign w_dec   = read_signal && !empty;
    assign w_space = !full || w_dec;

    always_comb begin
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        w_state_next = r_state;
        w_last_next  = r_last;
        w_burst_next = r_burst_cnt;
        case (r_state)
            IDLE: begin
                if (w_space) begin
                    // r_last==1 means producer 1 was served last, so 0 wins a tie
                    if (req0 && (!req1 || r_last)) begin
                        w_gnt0       = 1'b1;
                        w_state_next = BURST0;
                        w_last_next  = 1'b0;
                        w_burst_next = c_BURST_ONE;
                    end else if (req1) begin
                        w_gnt1       = 1'b1;
                        w_state_next = BURST1;
                        w_last_next  = 1'b1;
                        w_burst_next = c_BURST_ONE;
                    end
                end
            end
            BURST0: begin
                if (req0) begin
                    if (w_space) begin
                        if ((r_burst_cnt < c_MAX_BURST) || !req1) begin
                            w_gnt0 = 1'b1;
                            if (r_burst_cnt != c_BURST_SAT)
                                w_burst_next = r_burst_cnt + c_BURST_ONE;
                        end else begin
                            w_gnt1       = 1'b1;
                            w_state_next = BURST1;
                            w_last_next  = 1'b1;
                            w_burst_next = c_BURST_ONE;
                        end
                    end
                end else if (req1 && w_space) begin
                    w_gnt1       = 1'b1;
                    w_state_next = BURST1;
                    w_last_next  = 1'b1;
                    w_burst_next = c_BURST_ONE;
                end else begin
                    w_state_next = IDLE;
                    w_burst_next = '0;
                end
            end
            BURST1: begin
                if (req1) begin
                    if (w_space) begin
                        if ((r_burst_cnt < c_MAX_BURST) || !req0) begin
                            w_gnt1 = 1'b1;
                            if (r_burst_cnt != c_BURST_SAT)
                                w_burst_next = r_burst_cnt + c_BURST_ONE;
                        end else begin
                            w_gnt0       = 1'b1;
                            w_state_next = BURST0;
                            w_last_next  = 1'b0;
                            w_burst_next = c_BURST_ONE;
                        end
                    end
                end else if (req0 && w_space) begin
                    w_gnt0       = 1'b1;
                    w_state_next = BURST0;
                    w_last_next  = 1'b0;
                    w_burst_next = c_BURST_ONE;
                end else begin
                    w_state_next = IDLE;
                    w_burst_next = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_burst_next = '0;
            end
        endcase
    end

    // Grants are masked during reset so nothing is consumed while held
    assign gnt0 = w_gnt0 & rst;
    assign gnt1 = w_gnt1 & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_burst_cnt  <= '0;
            write_signal <= 1'b0;
            write_data   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last       <= w_last_next;
            r_burst_cnt  <= w_burst_next;
            write_signal <= w_gnt0 | w_gnt1;
            if (w_gnt0)
                write_data <= din0;
            else if (w_gnt1)
                write_data <= din1;
        end
    end

    fifo_occ_counter #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_occ (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_gnt0 | w_gnt1),
        .dec   (w_dec),
        .count (count),
        .full  (full),
        .empty (empty)
    );

`ifdef FIFO_ARB_STATS_EN
    localparam logic [15:0] c_STAT_MAX = 16'hFFFF;
    localparam logic [15:0] c_STAT_ONE = 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt0   <= '0;
            wr_cnt1   <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_gnt0 && (wr_cnt0 != c_STAT_MAX))
                wr_cnt0 <= wr_cnt0 + c_STAT_ONE;
            if (w_gnt1 && (wr_cnt1 != c_STAT_MAX))
                wr_cnt1 <= wr_cnt1 + c_STAT_ONE;
            if ((req0 || req1) && !(w_gnt0 || w_gnt1) && (stall_cnt != c_STAT_MAX))
                stall_cnt <= stall_cnt + c_STAT_ONE;
        end
    end
`endif

endmodule
`default_nettype wire
